// File: rtl/imm_ext_pipe.sv
// Registered immediate extender (zero/sign/upper/branch) with valid/ready handshake and flush.
// Define EXT_SKID_EN to build a two-entry skid buffer with a registered in_ready.
module imm_ext_pipe #(
  parameter int IMM_W = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IMM_W-1:0] in_imm,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);

  if (OUT_W < IMM_W + 2) begin : g_width_check
    $error("imm_ext_pipe: OUT_W must be at least IMM_W + 2");
  end

  function automatic logic signed [OUT_W-1:0] extend(input logic [IMM_W-1:0] imm,
                                                     input logic [1:0]       op);
    logic signed [OUT_W-1:0] sx;
    sx = {{(OUT_W-IMM_W){imm[IMM_W-1]}}, imm};
    case (op)
      2'b00:   extend = {{(OUT_W-IMM_W){1'b0}}, imm};
      2'b01:   extend = sx;
      2'b10:   extend = {imm, {(OUT_W-IMM_W){1'b0}}};
      default: extend = {sx[OUT_W-3:0], 2'b00};
    endcase
  endfunction

  logic signed [OUT_W-1:0] w_ext_p0;
  logic                    w_in_ready;
  logic                    w_accept;
  logic                    w_pop;

  logic                    r_vld_p1;
  logic signed [OUT_W-1:0] r_data_p1;
  logic [TAG_W-1:0]        r_tag_p1;

  assign w_ext_p0  = extend(in_imm, in_op);
  assign w_accept  = in_valid & w_in_ready & ~flush;
  assign w_pop     = r_vld_p1 & out_ready;
  assign in_ready  = w_in_ready;
  assign out_valid = r_vld_p1;
  assign out_data  = r_data_p1;
  assign out_tag   = r_tag_p1;

`ifdef EXT_SKID_EN
  logic                    r_skid_vld;
  logic signed [OUT_W-1:0] r_skid_data;
  logic [TAG_W-1:0]        r_skid_tag;

  // in_ready depends only on skid occupancy, so out_ready never reaches it combinationally.
  assign w_in_ready = rst_n & ~r_skid_vld;

  // Stage p0 -> p1: main entry refills from skid first, then from the input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld_p1    <= 1'b0;
      r_data_p1   <= '0;
      r_tag_p1    <= '0;
      r_skid_vld  <= 1'b0;
      r_skid_data <= '0;
      r_skid_tag  <= '0;
    end else if (flush) begin
      r_vld_p1   <= 1'b0;
      r_skid_vld <= 1'b0;
    end else if (!r_vld_p1 || w_pop) begin
      if (r_skid_vld) begin
        r_vld_p1   <= 1'b1;
        r_data_p1  <= r_skid_data;
        r_tag_p1   <= r_skid_tag;
        r_skid_vld <= 1'b0;
      end else if (w_accept) begin
        r_vld_p1  <= 1'b1;
        r_data_p1 <= w_ext_p0;
        r_tag_p1  <= in_tag;
      end else begin
        r_vld_p1 <= 1'b0;
      end
    end else if (w_accept) begin
      r_skid_vld  <= 1'b1;
      r_skid_data <= w_ext_p0;
      r_skid_tag  <= in_tag;
    end
  end
`else
  assign w_in_ready = rst_n & (~r_vld_p1 | out_ready);

  // Stage p0 -> p1: a push while popping replaces the departing entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld_p1  <= 1'b0;
      r_data_p1 <= '0;
      r_tag_p1  <= '0;
    end else if (flush) begin
      r_vld_p1 <= 1'b0;
    end else if (w_accept) begin
      r_vld_p1  <= 1'b1;
      r_data_p1 <= w_ext_p0;
      r_tag_p1  <= in_tag;
    end else if (w_pop) begin
      r_vld_p1 <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Scoreboard bench for imm_ext_pipe: directed mode/backpressure/flush/reset cases plus random traffic.
module tb_imm_ext_pipe;
  localparam int IMM_W = 16;
  localparam int OUT_W = 32;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst_n, in_valid, flush, rdy_drv, tgl_mode;
  logic             tgl_q = 1'b0;
  logic             in_ready, out_valid, out_ready;
  logic [IMM_W-1:0] in_imm;
  logic [1:0]       in_op;
  logic [TAG_W-1:0] in_tag;
  logic [OUT_W-1:0] out_data;
  logic [TAG_W-1:0] out_tag;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [OUT_W-1:0] d;
    logic [TAG_W-1:0] t;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) tgl_q <= ~tgl_q;
  assign out_ready = tgl_mode ? tgl_q : rdy_drv;

  imm_ext_pipe #(.IMM_W(IMM_W), .OUT_W(OUT_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_imm(in_imm), .in_op(in_op), .in_tag(in_tag), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: interpret the immediate as a number and apply the mode's arithmetic.
  function automatic logic [OUT_W-1:0] model(input logic [IMM_W-1:0] imm, input logic [1:0] op);
    longint u, s, r;
    u = longint'(imm);
    s = (u >= (longint'(1) << (IMM_W-1))) ? u - (longint'(1) << IMM_W) : u;
    case (op)
      2'd0:    r = u;
      2'd1:    r = s;
      2'd2:    r = u * (longint'(1) << (OUT_W-IMM_W));
      default: r = s * 4;
    endcase
    return r[OUT_W-1:0];
  endfunction

  bit               prev_acc = 1'b0;
  bit               prev_hold = 1'b0;
  logic [OUT_W-1:0] prev_d;
  logic [TAG_W-1:0] prev_t;

  always @(negedge clk) begin
    exp_t e;
    if (prev_acc) chk("latency_valid", 32'(out_valid), 32'd1);
    if (prev_hold) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_data", out_data, prev_d);
      chk("hold_tag", 32'(out_tag), 32'(prev_t));
    end
    if (!rst_n || flush) begin
      sb.delete();
      prev_acc  = 1'b0;
      prev_hold = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got tag %0d data 0x%08h, expected no output", out_tag, out_data);
        end else begin
          e = sb.pop_front();
          chk("out_data", out_data, e.d);
          chk("out_tag", 32'(out_tag), 32'(e.t));
        end
      end
      prev_acc = in_valid && in_ready;
      if (prev_acc) begin
        e.d = model(in_imm, in_op);
        e.t = in_tag;
        sb.push_back(e);
      end
      prev_hold = out_valid && !out_ready;
      prev_d    = out_data;
      prev_t    = out_tag;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [IMM_W-1:0] imm, input logic [1:0] op, input logic [TAG_W-1:0] tag);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_imm   = imm;
    in_op    = op;
    in_tag   = tag;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      step();
    end
    in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: tag %0d never accepted, expected acceptance", tag);
    end
  endtask

  logic [IMM_W-1:0] t_imm[6] = '{16'h8004, 16'h8004, 16'h8004, 16'h8004, 16'h7FFF, 16'h7FFF};
  logic [1:0]       t_op[6]  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd3};
  logic [OUT_W-1:0] t_exp[6] = '{32'h00008004, 32'hFFFF8004, 32'h80040000, 32'hFFFE0010,
                                 32'h00007FFF, 32'h0001FFFC};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_imm = '0; in_op = '0; in_tag = '0;
    flush = 1'b0; rdy_drv = 1'b0; tgl_mode = 1'b0;
    repeat (3) step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    step();
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    rdy_drv = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1;
      in_imm   = t_imm[k];
      in_op    = t_op[k];
      in_tag   = 5'(k + 1);
      step();
      chk("mode_valid", 32'(out_valid), 32'd1);
      chk("mode_data", out_data, t_exp[k]);
      chk("mode_tag", 32'(out_tag), 32'(k + 1));
    end
    in_valid = 1'b0;
    step();

`ifdef EXT_SKID_EN
    rdy_drv = 1'b0; in_valid = 1'b1; in_imm = 16'h0101; in_op = 2'd1; in_tag = 5'd1;
    step();
    chk("skid_ready_after1", 32'(in_ready), 32'd1);
    in_tag = 5'd2; in_imm = 16'h0202;
    step();
    chk("skid_ready_after2", 32'(in_ready), 32'd0);
    in_tag = 5'd3; in_imm = 16'h0303;
    repeat (2) step();
    chk("skid_stall_tag", 32'(out_tag), 32'd1);
    rdy_drv = 1'b1;
    step();
    chk("skid_drain_tag2", 32'(out_tag), 32'd2);
    chk("skid_ready_back", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("skid_drain_tag3", 32'(out_tag), 32'd3);
    step();
`else
    rdy_drv = 1'b0; in_valid = 1'b1; in_imm = 16'h0101; in_op = 2'd0; in_tag = 5'd1;
    step();
    in_valid = 1'b0;
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    rdy_drv = 1'b1;
    step();
`endif

    tgl_mode = 1'b1;
    for (int i = 1; i <= 4; i++) send(16'($urandom), 2'($urandom), 5'(10 + i));
    tgl_mode = 1'b0;
    rdy_drv  = 1'b1;
    repeat (3) step();

    rdy_drv = 1'b0;
    send(16'h1234, 2'd1, 5'd7);
`ifdef EXT_SKID_EN
    send(16'h4321, 2'd2, 5'd8);
`endif
    in_valid = 1'b1; in_imm = 16'hAAAA; in_op = 2'd0; in_tag = 5'h1F; flush = 1'b1;
    step();
    chk("flush_valid", 32'(out_valid), 32'd0);
    flush = 1'b0; in_valid = 1'b0; rdy_drv = 1'b1;
    repeat (3) begin
      step();
      chk("flush_no_stale", 32'(out_valid), 32'd0);
    end

    rdy_drv = 1'b0;
    send(16'hBEEF, 2'd2, 5'd9);
    chk("rm_held", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rm_in_ready_low", 32'(in_ready), 32'd0);
    step();
    chk("rm_out_valid", 32'(out_valid), 32'd0);
    chk("rm_out_data", out_data, 32'd0);
    chk("rm_out_tag", 32'(out_tag), 32'd0);
    chk("rm_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1; rdy_drv = 1'b1;
    step();
    chk("rm_in_ready_after", 32'(in_ready), 32'd1);
    repeat (3) begin
      step();
      chk("rm_no_stale", 32'(out_valid), 32'd0);
    end

    for (int c = 0; c < 600; c++) begin
      in_valid = ($urandom % 4) != 0;
      in_imm   = 16'($urandom);
      in_op    = 2'($urandom);
      in_tag   = 5'($urandom);
      rdy_drv  = ($urandom % 3) != 0;
      flush    = ($urandom % 20) == 0;
      rst_n    = ($urandom % 80) != 0;
      step();
    end
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; rdy_drv = 1'b1;
    repeat (5) step();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
